// File: rtl/log_converter.sv
// log_converter
//   Iterative Mitchell binary-to-log2 converter. An unsigned IN_W-bit operand
//   is normalised one bit per clock until its leading one reaches the MSB. The
//   shift count gives the characteristic k = IN_W-1-shifts. The bits below the
//   leading one become the fraction, so log2(x) ~ k + (x-2^k)/2^k.
//   The result {char, frac} is OUT_W = CHAR_W+FRAC_W bits wide, which matches
//   the 13-bit log-domain CPA operand.
//
// Configuration macro:
//   LOGCONV_CORR_EN - when defined, an extra CORR state follows NORM. It adds
//                     2^(FRAC_W-4) to fractions in the middle two quarter
//                     regions, which reduces Mitchell error. This costs one
//                     extra cycle of latency.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active low
//   in_data    in   unsigned operand (IN_W)
//   in_valid   in   operand valid
//   in_ready   out  converter idle and able to accept
//   out_log    out  {char[CHAR_W-1:0], frac[FRAC_W-1:0]}
//   out_zero   out  operand was zero (log undefined, out_log = 0)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
module log_converter #(
  parameter int IN_W   = 8,
  parameter int CHAR_W = 4,
  parameter int FRAC_W = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [CHAR_W+FRAC_W-1:0] out_log,
  output logic                     out_zero,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
`ifdef LOGCONV_CORR_EN
  localparam logic [1:0] CORR = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [IN_W-1:0]   sh;
  logic [CHAR_W-1:0] cnt;
  logic [CHAR_W-1:0] char_q;
  logic [FRAC_W-1:0] frac_q;
  logic              zero_q;
  logic [FRAC_W-1:0] frac_norm;

  // The bits below the normalised MSB are left-aligned into the fraction.
  // Spare LSBs are zero-padded. If the operand is wider than the fraction,
  // the low bits are truncated.
  generate
    if (FRAC_W > IN_W - 1) begin : g_pad
      assign frac_norm = {sh[IN_W-2:0], {(FRAC_W-IN_W+1){1'b0}}};
    end else if (FRAC_W == IN_W - 1) begin : g_exact
      assign frac_norm = sh[IN_W-2:0];
    end else begin : g_trunc
      assign frac_norm = sh[IN_W-2 -: FRAC_W];
    end
  endgenerate

`ifdef LOGCONV_CORR_EN
  logic [FRAC_W:0]   frac_bump;
  logic [FRAC_W-1:0] frac_corr;

  // Correction is applied only when the top two fraction bits are 01 or 10.
  // The bump saturates at all-ones, so it can never carry into the
  // characteristic.
  always_comb begin
    frac_bump = {1'b0, frac_q} + (FRAC_W+1)'(2 ** (FRAC_W - 4));
    frac_corr = frac_q;
    if (frac_q[FRAC_W-1] ^ frac_q[FRAC_W-2]) begin
      frac_corr = frac_bump[FRAC_W] ? {FRAC_W{1'b1}} : frac_bump[FRAC_W-1:0];
    end
  end
`endif

  // Control FSM and datapath registers.
  // An accepted operand always enters NORM first.
  // A zero operand is detected there, one cycle later, which puts its result
  // a single edge after acceptance.
  // A nonzero operand never shifts down to zero before its leading one reaches
  // the MSB, so sh == 0 in NORM only ever means a zero operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sh     <= '0;
      cnt    <= '0;
      char_q <= '0;
      frac_q <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh    <= in_data;
            cnt   <= '0;
            state <= NORM;
          end
        end
        NORM: begin
          if (sh == '0) begin
            zero_q <= 1'b1;
            char_q <= '0;
            frac_q <= '0;
            state  <= DONE;
          end else if (!sh[IN_W-1]) begin
            sh  <= sh << 1;
            cnt <= cnt + 1'b1;
          end else begin
            char_q <= CHAR_W'(IN_W - 1) - cnt;
            frac_q <= frac_norm;
`ifdef LOGCONV_CORR_EN
            state  <= CORR;
`else
            state  <= DONE;
`endif
          end
        end
`ifdef LOGCONV_CORR_EN
        CORR: begin
          frac_q <= frac_corr;
          state  <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            char_q <= '0;
            frac_q <= '0;
            zero_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is gated by rst_n, so every output reads 0 while reset is held.
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign out_log   = {char_q, frac_q};
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_log_converter.sv
// tb_log_converter
//   Self-checking bench for log_converter.
//   Directed steps cover exact powers, the extremes, the zero operand,
//   backpressure and a mid-conversion reset.
//   These are followed by randomized operands with random output stalls.
//   Expected results come from a log2 reference computed arithmetically.
//   Define LOGCONV_CORR_EN for both bench and RTL to check the corrected build.
module tb_log_converter;

  localparam int IN_W   = 8;
  localparam int CHAR_W = 4;
  localparam int FRAC_W = 9;
  localparam int OUT_W  = CHAR_W + FRAC_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] out_log;
  logic             out_zero;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  log_converter #(.IN_W(IN_W), .CHAR_W(CHAR_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_log   (out_log),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Reference: find the leading-one position k, then scale the remainder
  // (x - 2^k)/2^k into FRAC_W fraction bits. Latency is IN_W-k edges
  // (one for zero), plus one more for a nonzero operand in the corrected build.
  function automatic void model(input int x, output int expLog, output int expZero,
                                output int expLat);
    int k;
    int frac;
    if (x == 0) begin
      expLog  = 0;
      expZero = 1;
      expLat  = 1;
      return;
    end
    k = 0;
    while ((1 << (k + 1)) <= x) k++;
    frac = ((x - (1 << k)) << FRAC_W) >> k;
    expLat = IN_W - k;
`ifdef LOGCONV_CORR_EN
    if (frac >= (1 << (FRAC_W - 2)) && frac < 3 * (1 << (FRAC_W - 2))) begin
      frac = frac + (1 << (FRAC_W - 4));
      if (frac > (1 << FRAC_W) - 1) frac = (1 << FRAC_W) - 1;
    end
    expLat = expLat + 1;
`endif
    expLog  = (k << FRAC_W) + frac;
    expZero = 0;
  endfunction

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Waits for in_ready, presents x for one accepted edge (E0), then counts
  // edges until out_valid rises. The wait is bounded at 20 cycles.
  task automatic applyStimulus(input logic [IN_W-1:0] x, input string tag, output int lat);
    int waitCnt;
    waitCnt = 0;
    while (!in_ready && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput({tag, " in_ready"}, int'(in_ready), 1);
    in_data  = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = IN_W'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full transaction: checks latency and result, stalls for 'hold' cycles
  // while flooding in_valid with junk, then hands off and checks return to idle.
  task automatic runTransaction(input logic [IN_W-1:0] x, input int hold, input string tag);
    int expLog, expZero, expLat, lat;
    model(int'(x), expLog, expZero, expLat);
    applyStimulus(x, tag, lat);
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " out_log"}, int'(out_log), expLog);
    checkOutput({tag, " out_zero"}, int'(out_zero), expZero);
    checkOutput({tag, " busy in_ready"}, int'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = IN_W'($urandom);
      @(posedge clk); #1;
      checkOutput({tag, " stall out_valid"}, int'(out_valid), 1);
      checkOutput({tag, " stall out_log"}, int'(out_log), expLog);
      checkOutput({tag, " stall out_zero"}, int'(out_zero), expZero);
      checkOutput({tag, " stall in_ready"}, int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, " handoff out_valid"}, int'(out_valid), 0);
    checkOutput({tag, " handoff out_zero"}, int'(out_zero), 0);
    checkOutput({tag, " handoff in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int lat;
    logic [IN_W-1:0] rx;

    // Reset state while rst_n is held low.
    #12;
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_log", int'(out_log), 0);
    checkOutput("reset out_zero", int'(out_zero), 0);
    checkOutput("reset in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post-reset in_ready", int'(in_ready), 1);
    checkOutput("post-reset out_valid", int'(out_valid), 0);

    // Directed operands: MSB set, mid-range, all-ones, LSB only, zero.
    $display("[TB] directed operands");
    runTransaction(8'd128, 0, "x128");
    runTransaction(8'd6,   0, "x6");
    runTransaction(8'd255, 0, "x255");
    runTransaction(8'd1,   0, "x1");
    runTransaction(8'd0,   0, "x0");
    runTransaction(8'd96,  2, "x96");

    // Backpressure: hold the result for 10 cycles with in_valid flooding.
    $display("[TB] backpressure");
    runTransaction(8'd6, 10, "bp x6");
    @(posedge clk); #1;
    checkOutput("bp idle out_valid", int'(out_valid), 0);
    checkOutput("bp idle in_ready", int'(in_ready), 1);

    // Reset in the middle of normalising x=1; the operand must be dropped.
    $display("[TB] mid-conversion reset");
    in_data  = 8'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midrst out_valid", int'(out_valid), 0);
    checkOutput("midrst out_log", int'(out_log), 0);
    checkOutput("midrst out_zero", int'(out_zero), 0);
    checkOutput("midrst in_ready", int'(in_ready), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("after midrst in_ready", int'(in_ready), 1);
    checkOutput("after midrst out_valid", int'(out_valid), 0);
    runTransaction(8'd6, 0, "after midrst x6");

    // Randomized operands with random output stalls.
    $display("[TB] random operands");
    for (int n = 0; n < 300; n++) begin
      rx = IN_W'($urandom);
      if (n % 37 == 0) rx = '0;
      runTransaction(rx, int'($urandom_range(0, 3)), $sformatf("rnd%0d x%0d", n, rx));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
